// File: rtl/vga_fml_pkg.sv
// Shared types and helpers for the VGA FML read responder: FSM states, burst
// geometry and the tag extraction used by both the FML and DCB lookups.
package vga_fml_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } fml_state_e;

  localparam int BURST_LEN = 4;
  localparam int BEAT_W    = 2;
  localparam int WS_W      = 3;
  localparam int ADR_MAX_W = 32;

  // A burst covers 8 bytes, so the tag is everything above byte-address bit 2.
  function automatic logic [ADR_MAX_W-1:0] addr_tag(input logic [ADR_MAX_W-1:0] adr);
    return adr >> 3;
  endfunction

endpackage

// File: rtl/sram_word_reader.sv
// One asynchronous-SRAM word read: drives CE/OE/address and holds them for
// wait_states+1 cycles, flagging the last cycle so the caller can sample data.
module sram_word_reader
  import vga_fml_pkg::*;
#(
  parameter int sram_aw     = 20,
  parameter int wait_states = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [sram_aw-1:0] i_addr,
  output logic               o_done,
  output logic [15:0]        o_data,
  output logic [sram_aw-1:0] o_sram_addr,
  input  logic [15:0]        i_sram_data,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n
);

  // Handshake: i_start is taken when idle or in the cycle o_done is high; o_done
  // marks the single cycle where o_data is the word and is sampled by the caller.
  // A start on the o_done cycle chains the next word with CE/OE kept low.
  logic               r_busy;
  logic [WS_W-1:0]    r_cnt;
  logic [sram_aw-1:0] r_addr;
  logic               r_ce_n;
  logic               w_last;

  assign w_last = r_busy && (r_cnt == WS_W'(wait_states));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_addr <= '0;
      r_ce_n <= 1'b1;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_addr <= i_addr;
      r_ce_n <= 1'b0;
    end else if (w_last) begin
      r_busy <= 1'b0;
      r_ce_n <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done      = w_last;
  assign o_data      = i_sram_data;
  assign o_sram_addr = r_addr;
  assign o_sram_ce_n = r_ce_n;
  assign o_sram_oe_n = r_ce_n;

endmodule

// File: rtl/vga_fml_sram_resp.sv
// FML read responder: serves 4-beat bursts from async SRAM through a one-line
// buffer that also answers repeat requests and direct-cache-bus lookups.
module vga_fml_sram_resp
  import vga_fml_pkg::*;
#(
  parameter int fml_depth   = 25,
  parameter int sram_aw     = 20,
  parameter int wait_states = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [fml_depth-1:0] fml_adr,
  input  logic                 fml_stb,
  output logic                 fml_ack,
  output logic [15:0]          fml_do,
  input  logic                 dcb_stb,
  input  logic [fml_depth-1:0] dcb_adr,
  output logic [15:0]          dcb_dat,
  output logic                 dcb_hit,
  input  logic                 inval_i,
  output logic [sram_aw-1:0]   sram_addr_o,
  input  logic [15:0]          sram_data_i,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o
);

  localparam int TAG_W = fml_depth - 3;

  fml_state_e         r_state;
  fml_state_e         w_next_state;
  logic [TAG_W-1:0]   r_tag;
  logic               r_valid;
  logic               r_inval_seen;
  logic [BEAT_W-1:0]  r_word;
  logic [BEAT_W-1:0]  r_beat;
  logic [15:0]        r_buf [BURST_LEN];
  logic [15:0]        r_dcb_dat;
  logic               r_dcb_hit;

  logic [TAG_W-1:0]   w_fml_tag;
  logic [TAG_W-1:0]   w_dcb_tag;
  logic               w_hit;
  logic               w_miss;
  logic               w_rd_start;
  logic               w_rd_done;
  logic [15:0]        w_rd_data;
  logic [BEAT_W-1:0]  w_rd_word;
  logic [sram_aw-1:0] w_rd_addr;

  assign w_fml_tag = TAG_W'(addr_tag(ADR_MAX_W'(fml_adr)));
  assign w_dcb_tag = TAG_W'(addr_tag(ADR_MAX_W'(dcb_adr)));
  // An invalidate arriving with the request forces a refetch.
  assign w_hit     = r_valid && !inval_i && (w_fml_tag == r_tag);
  assign w_miss    = (r_state == ST_IDLE) && fml_stb && !w_hit;

  // First word comes straight from the request; the tag register is loaded on the same edge.
  assign w_rd_word = (r_state == ST_IDLE) ? '0 : r_word + 1'b1;
  assign w_rd_addr = (r_state == ST_IDLE) ? {w_fml_tag[sram_aw-3:0], w_rd_word}
                                          : {r_tag[sram_aw-3:0], w_rd_word};

  sram_word_reader #(
    .sram_aw     (sram_aw),
    .wait_states (wait_states)
  ) u_reader (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_start     (w_rd_start),
    .i_addr      (w_rd_addr),
    .o_done      (w_rd_done),
    .o_data      (w_rd_data),
    .o_sram_addr (sram_addr_o),
    .i_sram_data (sram_data_i),
    .o_sram_ce_n (sram_ce_n_o),
    .o_sram_oe_n (sram_oe_n_o)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_rd_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fml_stb) begin
          if (w_hit) begin
            w_next_state = ST_ACK;
          end else begin
            w_next_state = ST_FETCH;
            w_rd_start   = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (w_rd_done) begin
          if (r_word == BEAT_W'(BURST_LEN - 1)) w_next_state = ST_ACK;
          else                                  w_rd_start   = 1'b1;
        end
      end
      ST_ACK:   w_next_state = ST_BURST;
      ST_BURST: if (r_beat == BEAT_W'(BURST_LEN - 1)) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tag        <= '0;
      r_valid      <= 1'b0;
      r_inval_seen <= 1'b0;
      r_word       <= '0;
      r_beat       <= '0;
      r_dcb_dat    <= '0;
      r_dcb_hit    <= 1'b0;
      for (int i = 0; i < BURST_LEN; i++) r_buf[i] <= '0;
    end else begin
      if (inval_i) r_inval_seen <= 1'b1;
      if (w_miss) begin
        r_tag        <= w_fml_tag;
        r_word       <= '0;
        r_inval_seen <= 1'b0;
        r_valid      <= 1'b0;
      end
      if ((r_state == ST_FETCH) && w_rd_done) begin
        r_buf[r_word] <= w_rd_data;
        r_word        <= r_word + 1'b1;
      end
      if (r_state == ST_BURST) r_beat <= r_beat + 1'b1;
      else                     r_beat <= '0;
      // The line only becomes valid if no invalidate raced the fetch or burst.
      if ((r_state == ST_BURST) && (r_beat == BEAT_W'(BURST_LEN - 1)))
        r_valid <= !r_inval_seen;
      if (inval_i) r_valid <= 1'b0;

      r_dcb_hit <= dcb_stb && r_valid && !inval_i && (w_dcb_tag == r_tag);
      if (dcb_stb) r_dcb_dat <= r_buf[dcb_adr[2:1]];
    end
  end

  assign fml_ack = (r_state == ST_ACK);
  assign fml_do  = (r_state == ST_BURST) ? r_buf[r_beat] : 16'h0000;
  assign dcb_dat = r_dcb_dat;
  assign dcb_hit = r_dcb_hit;

endmodule
